// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and width helpers for the cache memory responder
// Purpose: FSM state enum, operation enum, default widths and width helper functions
//          used by cache_mem_responder and mem_block_array.
// Ports:   none (package).

package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_WB    = 1'b0,
        OP_ALLOC = 1'b1
    } op_e;

    localparam int ADDR_W_DEF   = 10;
    localparam int WORD_W_DEF   = 20;
    localparam int OFFSET_W_DEF = 2;
    localparam int LATENCY_DEF  = 4;
    localparam int CNT_W        = 4;

    // Width of one full block: WORD_W * BLOCK_WORDS.
    function automatic int block_w(input int word_w, input int offset_w);
        return word_w * (2 ** offset_w);
    endfunction

    // Number of blocks addressable by the block address (address minus offset bits).
    function automatic int depth(input int addr_w, input int offset_w);
        return 2 ** (addr_w - offset_w);
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// rtl/mem_block_array.sv - single-port synchronous block RAM with registered read
// Purpose: DEPTH x DATA_W backing store for cache blocks. Storage is never reset;
//          only the read data register is cleared by reset.
// Ports:   clk    - rising-edge clock
//          reset  - synchronous active-high, clears the read register only
//          we     - write enable, writes wdata to addr at the edge
//          re     - read enable, loads rdata from addr at the edge
//          addr   - block address shared by read and write
//          wdata  - block to write
//          rdata  - registered read block, held until the next enabled read

module mem_block_array
    import cache_pkg::*;
#(
    parameter int AW     = 8,
    parameter int DATA_W = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - memory-side responder for the cache miss path
// Purpose: accepts level-held writeback/alloc requests, waits a fixed latency,
//          commits written blocks or returns read blocks, and signals each
//          completion with a single-cycle mem_ready pulse.
// Ports:   clk             - rising-edge clock
//          reset           - synchronous active-high reset
//          start_writeback - level request: write mem_wdata block to memory
//          start_alloc     - level request: read block from memory
//          mem_addr        - request address, offset bits ignored
//          mem_wdata       - writeback block, word 0 in LSBs
//          mem_ready       - one-cycle completion pulse
//          mem_rdata       - last allocated block, valid from mem_ready
//          busy            - transaction in flight

module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int LATENCY  = LATENCY_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start_writeback,
    input  logic                                  start_alloc,
    input  logic [ADDR_W-1:0]                     mem_addr,
    input  logic [block_w(WORD_W, OFFSET_W)-1:0]  mem_wdata,
    output logic                                  mem_ready,
    output logic [block_w(WORD_W, OFFSET_W)-1:0]  mem_rdata,
    output logic                                  busy
);

    localparam int BLOCK_W = block_w(WORD_W, OFFSET_W);
    localparam int BADDR_W = ADDR_W - OFFSET_W;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
    localparam bit SINGLE_CYCLE = (LATENCY == 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [BADDR_W-1:0]   baddr_q, baddr_d;
    logic [BLOCK_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 accept;
    op_e                  req_op;
    logic [BADDR_W-1:0]   req_baddr;
    logic                 ram_we;
    logic                 ram_re;
    logic [BADDR_W-1:0]   ram_addr;
    logic                 unused_offset;

    assign req_baddr     = mem_addr[ADDR_W-1:OFFSET_W];
    assign unused_offset = ^mem_addr[OFFSET_W-1:0];

    // Writeback wins when both are raised; the alloc stays held and is taken next IDLE.
    assign accept = (state_q == IDLE) && (start_writeback || start_alloc);
    assign req_op = start_writeback ? OP_WB : OP_ALLOC;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        baddr_d = baddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    baddr_d = req_baddr;
                    wdata_d = mem_wdata;
                    cnt_d   = LAT_M1;
                    state_d = SINGLE_CYCLE ? RESP : BUSY;
                end
            end
            BUSY: begin
                // The counter is loaded with LATENCY-1 and hits 0 on the edge into
                // RESP, so RESP lands exactly LATENCY-1 edges after the accept edge.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_WB;
            baddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            baddr_q <= baddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // The RAM read is issued on the edge that enters RESP so the block is on
    // mem_rdata during the mem_ready cycle. With single-cycle latency that edge
    // is the accept edge itself, so the live request address is used.
    assign ram_re = ((state_q == BUSY) && (cnt_q <= 4'd1) && (op_q == OP_ALLOC))
                  || (SINGLE_CYCLE && accept && (req_op == OP_ALLOC));

    // The write commits on the edge leaving RESP; a reset on that edge drops it.
    assign ram_we   = (state_q == RESP) && (op_q == OP_WB) && !reset;
    assign ram_addr = (state_q == IDLE) ? req_baddr : baddr_q;

    mem_block_array #(
        .AW     (BADDR_W),
        .DATA_W (BLOCK_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign mem_ready = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - scoreboard bench for cache_mem_responder (LATENCY 4 and 1)

module tb_cache_mem_responder;

    localparam int AW = 10;
    localparam int WW = 20;
    localparam int OW = 2;
    localparam int BW = WW * (2 ** OW);

    typedef struct {
        int          cyc;
        bit          rd;
        logic [BW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // DUT A: LATENCY 4
    logic          reset_a, wb_a, al_a, ready_a, busy_a;
    logic [AW-1:0] addr_a;
    logic [BW-1:0] wdata_a, rdata_a;
    // DUT B: LATENCY 1
    logic          reset_b, wb_b, al_b, ready_b, busy_b;
    logic [AW-1:0] addr_b;
    logic [BW-1:0] wdata_b, rdata_b;

    cache_mem_responder #(.ADDR_W(AW), .WORD_W(WW), .OFFSET_W(OW), .LATENCY(4)) dut_a (
        .clk(clk), .reset(reset_a), .start_writeback(wb_a), .start_alloc(al_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_ready(ready_a),
        .mem_rdata(rdata_a), .busy(busy_a)
    );

    cache_mem_responder #(.ADDR_W(AW), .WORD_W(WW), .OFFSET_W(OW), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset_b), .start_writeback(wb_b), .start_alloc(al_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_ready(ready_b),
        .mem_rdata(rdata_b), .busy(busy_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per mem_ready pulse.
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    exp_t ea, eb;

    always @(negedge clk) begin
        if (ready_a) begin
            chk("a_ready_gap", {79'd0, prev_a}, '0);
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_ready actual=1 required=0 (cyc %0d)", cyc);
            end else begin
                ea = q_a.pop_front();
                chk("a_latency", BW'(ea.cyc), BW'(cyc)) ;
                if (ea.rd) chk("a_rdata", rdata_a, ea.data);
            end
        end
        prev_a = ready_a;
    end

    always @(negedge clk) begin
        if (ready_b) begin
            chk("b_ready_gap", {79'd0, prev_b}, '0);
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_ready actual=1 required=0 (cyc %0d)", cyc);
            end else begin
                eb = q_b.pop_front();
                chk("b_latency", BW'(eb.cyc), BW'(cyc));
                if (eb.rd) chk("b_rdata", rdata_b, eb.data);
            end
        end
        prev_b = ready_b;
    end

    // One request on DUT sel (0: A, 1: B); also checks busy spans LATENCY cycles.
    task automatic single(input bit sel, input bit wb, input logic [AW-1:0] addr,
                          input logic [BW-1:0] data, input logic [BW-1:0] exp_rd);
        int   lat;
        int   bc;
        exp_t e;
        lat = sel ? 1 : 4;
        @(posedge clk);
        #1;
        e.cyc  = cyc + lat;
        e.rd   = !wb;
        e.data = exp_rd;
        if (sel) begin
            wb_b = wb; al_b = !wb; addr_b = addr; wdata_b = data; q_b.push_back(e);
        end else begin
            wb_a = wb; al_a = !wb; addr_a = addr; wdata_a = data; q_a.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel) begin wb_b = 1'b0; al_b = 1'b0; end
        else     begin wb_a = 1'b0; al_a = 1'b0; end
        bc = 0;
        repeat (lat) begin
            @(negedge clk);
            bc += int'(sel ? busy_b : busy_a);
        end
        chk(sel ? "b_busy_cycles" : "a_busy_cycles", BW'(bc), BW'(lat));
        @(negedge clk);
        chk(sel ? "b_busy_after" : "a_busy_after", {79'd0, sel ? busy_b : busy_a}, '0);
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_a && n < 50);
        if (busy_a) begin
            checks++;
            errors++;
            $display("FAIL a_idle_timeout actual=busy required=idle (cyc %0d)", cyc);
        end
    endtask

    localparam logic [BW-1:0] D2 = {20'h44444, 20'h33333, 20'h22222, 20'h11111};
    localparam logic [BW-1:0] D4 = {20'hABCDE, 20'h01234, 20'hFEDCB, 20'h56789};
    localparam logic [BW-1:0] DP = {20'h0F0F0, 20'h5A5A5, 20'hC3C3C, 20'h96969};
    localparam logic [BW-1:0] D5 = {20'hFFFFF, 20'h00001, 20'h80000, 20'h12345};
    localparam logic [BW-1:0] D6 = {20'h76543, 20'h210FE, 20'hDCBA9, 20'h87654};

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset_a = 1'b1; wb_a = 1'b0; al_a = 1'b1; addr_a = '0; wdata_a = '0;
        reset_b = 1'b1; wb_b = 1'b0; al_b = 1'b0; addr_b = '0; wdata_b = '0;

        // 1: reset held two cycles with alloc requested
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", {79'd0, ready_a}, '0);
            chk("rst_busy",  {79'd0, busy_a},  '0);
            chk("rst_rdata", rdata_a, '0);
        end
        @(posedge clk);
        #1;
        reset_a = 1'b0; al_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {79'd0, busy_a}, '0);

        // 2: writeback, 3: alloc of same block at another offset
        single(1'b0, 1'b1, 10'h0A4, D2, '0);
        single(1'b0, 1'b0, 10'h0A7, '0, D2);

        // 4: both requests high; writeback first, alloc LATENCY+1 later
        @(posedge clk);
        #1;
        wb_a = 1'b1; al_a = 1'b1; addr_a = 10'h140; wdata_a = D4;
        e.cyc = cyc + 4; e.rd = 1'b0; e.data = '0; q_a.push_back(e);
        e.cyc = cyc + 9; e.rd = 1'b1; e.data = D4; q_a.push_back(e);
        @(posedge clk);
        #1;
        wb_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        al_a = 1'b0;
        wait_idle_a();

        // 5: write known contents, then reset mid-writeback and read back
        single(1'b0, 1'b1, 10'h200, DP, '0);
        chk("rdata_hold_after_write", rdata_a, D4);
        @(posedge clk);
        #1;
        wb_a = 1'b1; addr_a = 10'h200; wdata_a = D5;
        @(posedge clk);
        #1;
        wb_a = 1'b0;
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_a = 1'b0;
        @(negedge clk);
        chk("abort_busy",  {79'd0, busy_a}, '0);
        chk("abort_rdata", rdata_a, '0);
        repeat (6) @(negedge clk);
        single(1'b0, 1'b0, 10'h201, '0, DP);

        // 6: single-cycle latency build
        single(1'b1, 1'b1, 10'h3F0, D6, '0);
        single(1'b1, 1'b0, 10'h3F3, '0, D6);

        repeat (3) @(negedge clk);
        chk("a_queue_empty", BW'(q_a.size()), '0);
        chk("b_queue_empty", BW'(q_b.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
